imu_serial_tx: RTL and testbench

IMU_SERIAL_TX -- requirements
Module: imu_serial_tx

---
 rtl/imu_pkg.sv | 28 ++
 rtl/imu_serial_tx_if.sv | 30 +++
 rtl/imu_bit_timer.sv | 45 ++++
 rtl/imu_serial_tx.sv | 138 +++++++++++++
 tb/tb_imu_serial_tx.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imu_pkg.sv
// imu_pkg: shared definitions for the IMU serial transmitter.
//   imu_state_e    - transmit FSM states
//   AXIS_*         - two-bit axis identifiers carried in every frame
//   FRAME_OVERHEAD - non-payload bits per frame (start, two axis bits, parity, stop)
//   frame_bits()   - total bits per frame for a given payload width
package imu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_AXIS   = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } imu_state_e;

  localparam logic [1:0] AXIS_X    = 2'b00;
  localparam logic [1:0] AXIS_Y    = 2'b01;
  localparam logic [1:0] AXIS_Z    = 2'b10;
  localparam logic [1:0] AXIS_TEMP = 2'b11;

  localparam int FRAME_OVERHEAD = 5;

  function automatic int frame_bits(input int data_w);
    return data_w + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/imu_serial_tx_if.sv
// imu_serial_tx_if: sample handshake plus serial line signals.
//   s_valid/s_axis/s_data - sample offered by the source
//   s_ready               - transmitter can take a sample this cycle
//   ser_out/ser_en        - serial line and frame-active strobe
//   busy/done             - transmitter status
// Handshake: a sample transfers on a rising clk edge where s_valid and
// s_ready are both high; the source keeps s_valid, s_axis and s_data stable
// until that edge, and s_ready never depends on s_valid.
interface imu_serial_tx_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [1:0]        s_axis;
  logic [DATA_W-1:0] s_data;
  logic              ser_out;
  logic              ser_en;
  logic              busy;
  logic              done;

  modport master (
    output s_valid, s_axis, s_data,
    input  s_ready, ser_out, ser_en, busy, done
  );

  modport slave (
    input  s_valid, s_axis, s_data,
    output s_ready, ser_out, ser_en, busy, done
  );
endinterface

// File: rtl/imu_bit_timer.sv
// imu_bit_timer: bit-period down-counter.
//   clk, nrst - clock and asynchronous active-low reset
//   clr       - force the count to zero (frame ends or is aborted)
//   start     - load the reload value for the first bit of a frame
//   run       - a frame is in progress
//   tick      - high on the last cycle of each bit while running
module imu_bit_timer #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  // The count reaches zero only on the last cycle of a bit and is reloaded
  // there, so it never decrements past zero, even with CLK_DIV of 1.
  assign tick = run && (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (start || tick) begin
      cnt_d = RELOAD;
    end else if (run) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imu_serial_tx.sv
// imu_serial_tx: serialises one IMU sample per frame:
//   start(0), axis[1:0], data MSB first, even parity, stop(1).
//   clk, nrst - clock and asynchronous active-low reset
//   en        - low aborts any frame and holds the block idle
//   bus       - sample handshake and serial outputs (slave side)
//   dbg_state - current FSM state
module imu_serial_tx
  import imu_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int DATA_W  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  imu_serial_tx_if.slave   bus,
  output imu_state_e       dbg_state
);

  localparam int SR_W  = DATA_W + 2;
  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  imu_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               par_q, par_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_en_q, ser_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hs;
  logic               tick;
  logic               timer_clr;
  logic               timer_run;

  // nrst gates s_ready so nothing is offered while reset is held.
  assign bus.s_ready = (state_q == ST_IDLE) && en && nrst;
  assign hs          = bus.s_valid && bus.s_ready;
  assign timer_clr   = (state_d == ST_IDLE);
  assign timer_run   = (state_q != ST_IDLE);

  imu_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (timer_clr),
    .start (hs),
    .run   (timer_run),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    par_d   = par_q;
    done_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      sr_d    = '0;
      par_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (hs) begin
          sr_d    = {bus.s_axis, bus.s_data};
          par_d   = ^{bus.s_axis, bus.s_data};
          idx_d   = '0;
          state_d = ST_START;
        end
        ST_START: if (tick) state_d = ST_AXIS;
        ST_AXIS: if (tick) begin
          sr_d = sr_q << 1;
          if (idx_q == IDX_W'(1)) begin
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_DATA: if (tick) begin
          sr_d = sr_q << 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_PARITY: if (tick) state_d = ST_STOP;
        ST_STOP: if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Line outputs are decoded from the next state so the registered
    // values line up with the state they belong to.
    ser_en_d = (state_d != ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_START:         ser_out_d = 1'b0;
      ST_AXIS, ST_DATA: ser_out_d = sr_d[SR_W-1];
      ST_PARITY:        ser_out_d = par_d;
      default:          ser_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      ser_out_q <= 1'b1;
      ser_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      ser_out_q <= ser_out_d;
      ser_en_q  <= ser_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ser_out = ser_out_q;
  assign bus.ser_en  = ser_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imu_serial_tx.sv
// tb_imu_serial_tx: two transmitters (CLK_DIV 4 and 1) checked every cycle
// against a frame-level model, plus literal checks on hand-worked frames.
module tb_imu_serial_tx;
  import imu_pkg::*;

  localparam int DW   = 16;
  localparam int FB   = DW + 5;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  logic en;
  always #5 clk = ~clk;

  imu_serial_tx_if #(.DATA_W(DW)) if0 ();
  imu_serial_tx_if #(.DATA_W(DW)) if1 ();
  imu_state_e dbg0, dbg1;

  imu_serial_tx #(.CLK_DIV(DIV0), .DATA_W(DW)) dut0 (
    .clk(clk), .nrst(nrst), .en(en), .bus(if0), .dbg_state(dbg0));
  imu_serial_tx #(.CLK_DIV(DIV1), .DATA_W(DW)) dut1 (
    .clk(clk), .nrst(nrst), .en(en), .bus(if1), .dbg_state(dbg1));

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a 21-bit word sent MSB first; pos counts cycles into it.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic [20:0] frame;
    logic [31:0] pos;
  } model_t;

  model_t m0, m1;

  function automatic model_t m_step(input model_t m, input int cdiv, input logic e,
                                    input logic v, input logic [1:0] ax, input logic [DW-1:0] d);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (!e) begin
      n.busy = 1'b0;
      n.pos  = '0;
    end else if (m.busy) begin
      if (int'(m.pos) == FB * cdiv - 1) begin
        n.busy = 1'b0;
        n.done = 1'b1;
        n.pos  = '0;
      end else begin
        n.pos = m.pos + 1;
      end
    end else if (v) begin
      n.busy  = 1'b1;
      n.pos   = '0;
      n.frame = {1'b0, ax, d, ^{ax, d}, 1'b1};
    end
    return n;
  endfunction

  task automatic cmp_inst(input string tag, input model_t m, input int cdiv,
                          input logic so, input logic se, input logic bz,
                          input logic dn, input logic rd);
    int   bi;
    logic exp_so;
    bi = 20 - int'(m.pos) / cdiv;
    exp_so = m.busy ? m.frame[bi] : 1'b1;
    check({tag, ".ser_out"}, so, exp_so);
    check({tag, ".ser_en"},  se, m.busy);
    check({tag, ".busy"},    bz, m.busy);
    check({tag, ".done"},    dn, m.done);
    check({tag, ".s_ready"}, rd, !m.busy && en && nrst);
  endtask

  // Compare process: inputs change on the falling edge, so at negedge+1 the
  // inputs for the coming rising edge and the current outputs are stable.
  always @(negedge clk) begin
    #1;
    if (!nrst) begin
      m0 = '0;
      m1 = '0;
    end
    cmp_inst("dut0", m0, DIV0, if0.ser_out, if0.ser_en, if0.busy, if0.done, if0.s_ready);
    cmp_inst("dut1", m1, DIV1, if1.ser_out, if1.ser_en, if1.busy, if1.done, if1.s_ready);
    if (nrst) begin
      m0 = m_step(m0, DIV0, en, if0.s_valid && m0.busy == 1'b0 && en, if0.s_axis, if0.s_data);
      m1 = m_step(m1, DIV1, en, if1.s_valid && m1.busy == 1'b0 && en, if1.s_axis, if1.s_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int inst, input logic v, input logic [1:0] ax, input logic [DW-1:0] d);
    if (inst == 0) begin
      if0.s_valid = v; if0.s_axis = ax; if0.s_data = d;
    end else begin
      if1.s_valid = v; if1.s_axis = ax; if1.s_data = d;
    end
  endtask

  // Drop valid and scramble the payload lines after a handshake.
  task automatic release_in(input int inst);
    set_in(inst, 1'b0, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 65535)));
  endtask

  // Called on a falling edge; returns on the falling edge of the first
  // frame cycle with s_valid still high.
  task automatic offer(input int inst, input logic [1:0] ax, input logic [DW-1:0] d,
                       output logic acc_done, output logic acc_ser_en, output int waits);
    int n;
    logic r;
    n = 0;
    set_in(inst, 1'b1, ax, d);
    #1;
    r = (inst == 0) ? if0.s_ready : if1.s_ready;
    while (!r && n < 2000) begin
      @(negedge clk); #1;
      n++;
      r = (inst == 0) ? if0.s_ready : if1.s_ready;
    end
    if (!r) check("offer_timeout", 0, 1);
    acc_done   = (inst == 0) ? if0.done : if1.done;
    acc_ser_en = (inst == 0) ? if0.ser_en : if1.ser_en;
    waits = n;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int inst);
    int   n;
    logic b;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
      b = (inst == 0) ? if0.busy : if1.busy;
    end while (b && n < 5000);
    if (b) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic rand_frames(input int inst, input int count);
    logic ad, ae;
    int   w;
    for (int k = 0; k < count; k++) begin
      offer(inst, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 65535)), ad, ae, w);
      if ($urandom_range(0, 2) != 0) begin
        release_in(inst);
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end
    release_in(inst);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [20:0] fr;
  logic [83:0] cap, expv;
  logic        dseen, ad, ae;
  int          w;

  initial begin
    nrst = 1'b1;
    en   = 1'b1;
    set_in(0, 1'b0, 2'b00, '0);
    set_in(1, 1'b0, 2'b00, '0);
    #2 nrst = 1'b0;
    #2;
    // Reset values with en high: s_ready still low.
    check("rst_ser_out", if0.ser_out, 1'b1);
    check("rst_ser_en",  if0.ser_en,  1'b0);
    check("rst_busy",    if0.busy,    1'b0);
    check("rst_done",    if0.done,    1'b0);
    check("rst_s_ready", if0.s_ready, 1'b0);
    check("rst_state",   dbg0,        ST_IDLE);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, CLK_DIV 4: axis 01, data A5C3 (1-count 9, parity 1).
    fr = {1'b0, 2'b01, 16'hA5C3, 1'b1, 1'b1};
    offer(0, 2'b01, 16'hA5C3, ad, ae, w);
    release_in(0);
    dseen = 1'b0;
    for (int i = 0; i < 84; i++) begin
      #2;
      cap[83-i]  = if0.ser_out;
      expv[83-i] = fr[20 - i / 4];
      dseen      = dseen | if0.done;
      @(negedge clk);
    end
    check("a5c3_line", cap, expv);
    check("a5c3_no_early_done", dseen, 1'b0);
    #2;
    check("a5c3_done_at_84", if0.done, 1'b1);
    check("a5c3_idle_line", if0.ser_out, 1'b1);
    @(negedge clk);

    // Back-to-back with s_valid held: axis 10, 0000 then FFFF.
    offer(0, 2'b10, 16'h0000, ad, ae, w);
    offer(0, 2'b10, 16'hFFFF, ad, ae, w);
    check("b2b_accept_in_done", ad, 1'b1);
    check("b2b_gap_idle", ae, 1'b0);
    release_in(0);
    #2;
    check("b2b_start_bit", if0.ser_out, 1'b0);
    check("b2b_start_en",  if0.ser_en,  1'b1);
    repeat (76) @(negedge clk);
    #2;
    // axis 10 + FFFF has 17 ones, so the even-parity bit is 1.
    check("b2b_parity_ffff", if0.ser_out, 1'b1);
    wait_idle(0);

    // Backpressure: offer while busy; held until the done cycle.
    offer(0, 2'b00, 16'h1357, ad, ae, w);
    release_in(0);
    repeat (10) @(negedge clk);
    offer(0, 2'b11, 16'h1234, ad, ae, w);
    check("bp_held", w > 0, 1'b1);
    check("bp_accept_in_done", ad, 1'b1);
    release_in(0);
    wait_idle(0);

    // Abort at cycle 30 of a frame.
    offer(0, 2'b01, DW'($urandom_range(0, 65535)), ad, ae, w);
    release_in(0);
    repeat (30) @(negedge clk);
    en = 1'b0;
    @(negedge clk); #2;
    check("abort_ser_out", if0.ser_out, 1'b1);
    check("abort_busy",    if0.busy,    1'b0);
    check("abort_ser_en",  if0.ser_en,  1'b0);
    dseen = if0.done;
    repeat (2) begin @(negedge clk); #2; dseen = dseen | if0.done; end
    check("abort_no_done", dseen, 1'b0);
    // s_valid raised while en is low: no handshake.
    @(negedge clk);
    set_in(0, 1'b1, 2'b10, 16'h00FF);
    @(negedge clk); #2;
    check("en_low_no_accept", if0.busy, 1'b0);
    @(negedge clk);
    release_in(0);
    en = 1'b1;
    offer(0, 2'b10, 16'h0F0F, ad, ae, w);
    release_in(0);
    wait_idle(0);

    // Asynchronous reset mid-DATA, asserted between clock edges.
    offer(0, 2'b10, DW'($urandom_range(0, 65535)), ad, ae, w);
    release_in(0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("arst_ser_out", if0.ser_out, 1'b1);
    check("arst_ser_en",  if0.ser_en,  1'b0);
    check("arst_busy",    if0.busy,    1'b0);
    check("arst_state",   dbg0,        ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("arst_no_resume", if0.busy, 1'b0);
    @(negedge clk);

    // Minimum divider: axis 11, data 8001 (1-count 4, parity 0).
    fr = {1'b0, 2'b11, 16'h8001, 1'b0, 1'b1};
    offer(1, 2'b11, 16'h8001, ad, ae, w);
    release_in(1);
    dseen = 1'b0;
    cap  = '0;
    expv = '0;
    for (int i = 0; i < 21; i++) begin
      #2;
      cap[20-i]  = if1.ser_out;
      expv[20-i] = fr[20 - i];
      dseen      = dseen | if1.done;
      @(negedge clk);
    end
    check("div1_line", cap, expv);
    check("div1_no_early_done", dseen, 1'b0);
    #2;
    check("div1_done_at_21", if1.done, 1'b1);
    @(negedge clk);

    // Randomised traffic on both instances with occasional en drops.
    fork
      rand_frames(0, 12);
      rand_frames(1, 40);
      begin
        repeat (3) begin
          repeat ($urandom_range(50, 300)) @(negedge clk);
          en = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          en = 1'b1;
        end
      end
    join
    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
